uart_debug_bridge: RTL and testbench
====================================

# uart_debug_bridge

UART-to-Wishbone debug bridge: the on-chip responder to the host debug protocol. It consumes command bytes from the system UART receiver, performs single 32-bit Wishbone master transactions, and returns response bytes through the UART transmitter. It also issues a "go" request with a 32-bit target address for the LM32 boot path. It sits between the system `uart` instance and the Wishbone interconnect as an additional master.

## Interface
- `timeout_cycles`, 1024: Wishbone cycles to wait for `wb_ack_i` before aborting (see Configuration).
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset. This is the already-decided clock/reset scheme: one clock; reset is asynchronous and active-low.
- `rx_data` in 8: received byte.
- `rx_avail` in 1: received byte valid.
- `rx_ack` out 1: one-cycle pulse that consumes `rx_data`.
- `tx_data` out 8: byte to transmit.
- `tx_wr` out 1: one-cycle transmit strobe.
- `tx_busy` in 1: transmitter busy.
- `wb_adr_o` out 32: Wishbone address.
- `wb_dat_o` out 32: write data.
- `wb_dat_i` in 32: read data.
- `wb_sel_o` out 4: always 4'hF while a cycle is active, otherwise 0.
- `wb_we_o` out 1: write enable.
- `wb_cyc_o`, `wb_stb_o` out 1: cycle and strobe. Both are asserted together.
- `wb_ack_i` in 1: slave acknowledge.
- `go_adr` out 32: address of the last go command.
- `go_stb` out 1: one-cycle pulse on a go command.

## Operation
- Commands. Address and data fields are 4 bytes each, sent MSB first.
  - `'r'` (0x72) + addr: read. The 4 data bytes are returned MSB first.
  - `'w'` (0x77) + addr + data: write. The bridge replies with `'K'` (0x4B).
  - `'g'` (0x67) + addr: go. `go_adr` is set to addr, `go_stb` pulses, and the bridge replies with `'K'`.
  - Any other byte received in IDLE is consumed and ignored.
- Receive rule: a byte is consumed in a cycle where `rx_avail`=1 and `rx_ack`=0. `rx_ack` is pulsed high in the next cycle. After a pulse, `rx_ack` stays low for at least one cycle.
- States:
  - IDLE → ADDR on r, w or g.
  - ADDR: 4 bytes are shifted into the address register. Then → DATA (w), BUS (r), or GO (g).
  - DATA: 4 bytes are shifted into the data register, then → BUS.
  - BUS: `cyc`, `stb` and `sel` are asserted until `wb_ack_i`. On ack, read data is latched. Then → SEND.
  - GO: `go_stb`=1 for one cycle, then → SEND.
  - SEND: 1 or 4 response bytes are transmitted, then → IDLE.
- Transmit rule: `tx_wr` pulses for one cycle with `tx_data` valid. It is issued only when `tx_busy`=0 and at least 2 cycles have passed since the previous `tx_wr`. This covers the one-cycle delay before `tx_busy` rises.
- A 2-bit byte counter is used for field and response sequencing. It wraps 3→0 when moving to the next field.
- While the bridge is outside IDLE, bytes are not consumed during BUS, GO or SEND. They remain pending in the UART.

## Timing
- Reset values: all outputs are 0, `go_adr`=0, and the state is IDLE.
- Asserting reset mid-transaction drops `cyc`/`stb` immediately (asynchronously) and discards partial commands.
- Wishbone:
  - `cyc`/`stb`/`adr`/`we`/`dat_o` are registered and assert in the cycle after entering BUS.
  - They deassert in the cycle after `wb_ack_i`=1 is sampled.
  - A combinational ack in the same cycle as stb is allowed.
- Read latency from the last address byte consumed to the first `tx_wr` is at most 3 cycles plus the ack wait.
- `go_stb` is asserted in the cycle after the 4th address byte is consumed. `go_adr` is valid in the same cycle and holds afterwards.
- If `rx_avail` and the state transition occur in the same cycle, the transition has priority. Consumption resumes in IDLE.

## Configuration
- `DEBUG_BRIDGE_TIMEOUT_EN` defined:
  - A counter runs in BUS.
  - When it reaches `timeout_cycles` without an ack, `cyc`/`stb` drop and the bridge sends a single `'E'` (0x45) in place of the normal response. For reads, 'E' replaces the 4 data bytes.
  - The counter clears on entering BUS.
- `DEBUG_BRIDGE_TIMEOUT_EN` undefined: BUS waits for the ack indefinitely, and no timeout logic is present.

## Structure
- A shared package `debug_bridge_pkg` holds:
  - the state enum;
  - command constants `CMD_READ`/`CMD_WRITE`/`CMD_GO`;
  - response constants `RSP_OK`/`RSP_ERR`.
- One natural sub-module, `debug_bridge_tx`: a response serializer holding the tx handshake, the byte counter, and 1- or 4-byte word sequencing.

## Test plan
- Write: host sends 77 00 00 10 00 DE AD BE EF. Required: one Wishbone write to `adr`=0x00001000 with `dat`=0xDEADBEEF, `we`=1, `sel`=F; the host then receives 4B.
- Read: host sends 72 00 00 10 00 and the slave returns 0xDEADBEEF. Required: the host receives DE AD BE EF in that order, and `we`=0 during the cycle.
- Go: host sends 67 00 00 00 00 (the boot sequence). Required: `go_stb` is a single-cycle pulse, `go_adr`=0x00000000, and the host receives 4B.
- Junk: host sends 00 then a read command. The 00 is ignored and the read completes normally. Also verify that `rx_ack` never pulses on consecutive cycles.
- Timeout (macro on, `timeout_cycles`=16): the slave never acks. Required: `cyc` drops after 16 cycles and the host receives 45 only.
- Reset: assert `reset_n`=0 during BUS. Required: all outputs are 0 immediately; after release, a fresh read command succeeds.

Source files
------------

// File: rtl/debug_bridge_pkg.sv
// rtl/debug_bridge_pkg.sv - shared states and protocol bytes for the UART debug bridge
package debug_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_BUS,
        ST_GO,
        ST_SEND
    } state_t;

    localparam logic [7:0] CMD_READ  = 8'h72;
    localparam logic [7:0] CMD_WRITE = 8'h77;
    localparam logic [7:0] CMD_GO    = 8'h67;
    localparam logic [7:0] RSP_OK    = 8'h4B;
    localparam logic [7:0] RSP_ERR   = 8'h45;

endpackage

// File: rtl/debug_bridge_tx.sv
// rtl/debug_bridge_tx.sv - response serializer: sends 1 or 4 bytes MSB first with UART pacing
module debug_bridge_tx (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] word,
    input  logic        four,
    input  logic        tx_busy,
    output logic [7:0]  tx_data,
    output logic        tx_wr,
    output logic        done
);

    logic        active_q, active_d;
    logic        four_q, four_d;
    logic [31:0] sreg_q, sreg_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [1:0]  gap_q, gap_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_wr_q, tx_wr_d;
    logic        issue;
    logic        last;

    // Issue a byte only when the UART is idle and the previous strobe is at least 2 cycles old,
    // since tx_busy only rises one cycle after the strobe.
    always_comb begin
        issue     = active_q && !tx_busy && (gap_q == 2'd0);
        last      = !four_q || (cnt_q == 2'd3);
        done      = issue && last;
        active_d  = active_q;
        four_d    = four_q;
        sreg_d    = sreg_q;
        cnt_d     = cnt_q;
        tx_data_d = tx_data_q;
        tx_wr_d   = issue;
        gap_d     = (gap_q != 2'd0) ? gap_q - 2'd1 : 2'd0;
        if (start) begin
            active_d = 1'b1;
            four_d   = four;
            sreg_d   = word;
            cnt_d    = 2'd0;
        end else if (issue) begin
            tx_data_d = sreg_q[31:24];
            sreg_d    = {sreg_q[23:0], 8'h00};
            cnt_d     = cnt_q + 2'd1;
            gap_d     = 2'd2;
            if (last) begin
                active_d = 1'b0;
                cnt_d    = 2'd0;
            end
        end
    end

    // Serializer state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active_q  <= 1'b0;
            four_q    <= 1'b0;
            sreg_q    <= '0;
            cnt_q     <= '0;
            gap_q     <= '0;
            tx_data_q <= '0;
            tx_wr_q   <= 1'b0;
        end else begin
            active_q  <= active_d;
            four_q    <= four_d;
            sreg_q    <= sreg_d;
            cnt_q     <= cnt_d;
            gap_q     <= gap_d;
            tx_data_q <= tx_data_d;
            tx_wr_q   <= tx_wr_d;
        end
    end

    assign tx_data = tx_data_q;
    assign tx_wr   = tx_wr_q;

endmodule

// File: rtl/uart_debug_bridge.sv
// rtl/uart_debug_bridge.sv - UART command decoder driving one Wishbone master port; DEBUG_BRIDGE_TIMEOUT_EN adds a bus timeout
module uart_debug_bridge
    import debug_bridge_pkg::*;
#(
    parameter int timeout_cycles = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_avail,
    output logic        rx_ack,
    output logic [7:0]  tx_data,
    output logic        tx_wr,
    input  logic        tx_busy,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    output logic [31:0] go_adr,
    output logic        go_stb
);

    state_t      state_q, state_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [1:0]  bcnt_q, bcnt_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic        rx_ack_q, rx_ack_d;
    logic        cyc_q, cyc_d;
    logic        we_q, we_d;
    logic [31:0] wb_adr_q, wb_adr_d;
    logic [31:0] wb_dat_q, wb_dat_d;
    logic        go_stb_q, go_stb_d;
    logic [31:0] go_adr_q, go_adr_d;
    logic        consume;
    logic        tmo_hit;
    logic        tx_start;
    logic [31:0] tx_word;
    logic        tx_four;
    logic        tx_done;

`ifdef DEBUG_BRIDGE_TIMEOUT_EN
    localparam int TW = $clog2(timeout_cycles + 1);
    logic [TW-1:0] tmo_q, tmo_d;

    // Timeout counter is held at zero outside BUS so every bus cycle starts a fresh count.
    always_comb begin
        tmo_d = (state_q == ST_BUS) ? tmo_q + TW'(1) : '0;
    end

    // Timeout counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) tmo_q <= '0;
        else          tmo_q <= tmo_d;
    end

    assign tmo_hit = (state_q == ST_BUS) && (tmo_q == TW'(timeout_cycles - 1));
`else
    assign tmo_hit = 1'b0;
    if (timeout_cycles < 1) begin : g_timeout_cycles_invalid
    end
`endif

    // Command decoder: byte intake, field shifting and bus/go/response sequencing.
    always_comb begin
        consume  = rx_avail && !rx_ack_q &&
                   (state_q == ST_IDLE || state_q == ST_ADDR || state_q == ST_DATA);
        state_d  = state_q;
        cmd_d    = cmd_q;
        bcnt_d   = bcnt_q;
        adr_d    = adr_q;
        dat_d    = dat_q;
        rx_ack_d = consume;
        cyc_d    = cyc_q;
        we_d     = we_q;
        wb_adr_d = wb_adr_q;
        wb_dat_d = wb_dat_q;
        go_stb_d = 1'b0;
        go_adr_d = go_adr_q;
        tx_start = 1'b0;
        tx_word  = {RSP_OK, 24'h000000};
        tx_four  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (consume && (rx_data == CMD_READ || rx_data == CMD_WRITE || rx_data == CMD_GO)) begin
                    cmd_d   = rx_data;
                    bcnt_d  = 2'd0;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (consume) begin
                    adr_d  = {adr_q[23:0], rx_data};
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        if (cmd_q == CMD_WRITE) begin
                            state_d = ST_DATA;
                        end else if (cmd_q == CMD_GO) begin
                            state_d  = ST_GO;
                            go_stb_d = 1'b1;
                            go_adr_d = adr_d;
                        end else begin
                            state_d  = ST_BUS;
                            cyc_d    = 1'b1;
                            we_d     = 1'b0;
                            wb_adr_d = adr_d;
                        end
                    end
                end
            end
            ST_DATA: begin
                if (consume) begin
                    dat_d  = {dat_q[23:0], rx_data};
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        state_d  = ST_BUS;
                        cyc_d    = 1'b1;
                        we_d     = 1'b1;
                        wb_adr_d = adr_q;
                        wb_dat_d = dat_d;
                    end
                end
            end
            ST_BUS: begin
                if (wb_ack_i) begin
                    cyc_d    = 1'b0;
                    we_d     = 1'b0;
                    state_d  = ST_SEND;
                    tx_start = 1'b1;
                    if (!we_q) begin
                        dat_d   = wb_dat_i;
                        tx_word = wb_dat_i;
                        tx_four = 1'b1;
                    end
                end else if (tmo_hit) begin
                    cyc_d    = 1'b0;
                    we_d     = 1'b0;
                    state_d  = ST_SEND;
                    tx_start = 1'b1;
                    tx_word  = {RSP_ERR, 24'h000000};
                end
            end
            ST_GO: begin
                state_d  = ST_SEND;
                tx_start = 1'b1;
            end
            ST_SEND: begin
                if (tx_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bridge state and registered outputs; reset drops the bus cycle immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cmd_q    <= '0;
            bcnt_q   <= '0;
            adr_q    <= '0;
            dat_q    <= '0;
            rx_ack_q <= 1'b0;
            cyc_q    <= 1'b0;
            we_q     <= 1'b0;
            wb_adr_q <= '0;
            wb_dat_q <= '0;
            go_stb_q <= 1'b0;
            go_adr_q <= '0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            bcnt_q   <= bcnt_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            rx_ack_q <= rx_ack_d;
            cyc_q    <= cyc_d;
            we_q     <= we_d;
            wb_adr_q <= wb_adr_d;
            wb_dat_q <= wb_dat_d;
            go_stb_q <= go_stb_d;
            go_adr_q <= go_adr_d;
        end
    end

    debug_bridge_tx u_tx (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (tx_start),
        .word    (tx_word),
        .four    (tx_four),
        .tx_busy (tx_busy),
        .tx_data (tx_data),
        .tx_wr   (tx_wr),
        .done    (tx_done)
    );

    assign rx_ack   = rx_ack_q;
    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = cyc_q;
    assign wb_sel_o = {4{cyc_q}};
    assign wb_we_o  = we_q;
    assign wb_adr_o = wb_adr_q;
    assign wb_dat_o = wb_dat_q;
    assign go_stb   = go_stb_q;
    assign go_adr   = go_adr_q;

endmodule

// File: tb/tb_uart_debug_bridge.sv
// tb/tb_uart_debug_bridge.sv - directed self-checking bench for uart_debug_bridge
`timescale 1ns/1ps
module tb_uart_debug_bridge;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_avail = 1'b0;
    logic        rx_ack;
    logic [7:0]  tx_data;
    logic        tx_wr;
    logic        tx_busy = 1'b0;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i = 32'hDEADBEEF;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_ack_i = 1'b0;
    logic [31:0] go_adr;
    logic        go_stb;

    always #5 clk = ~clk;

    uart_debug_bridge #(.timeout_cycles(16)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .rx_data  (rx_data),
        .rx_avail (rx_avail),
        .rx_ack   (rx_ack),
        .tx_data  (tx_data),
        .tx_wr    (tx_wr),
        .tx_busy  (tx_busy),
        .wb_adr_o (wb_adr_o),
        .wb_dat_o (wb_dat_o),
        .wb_dat_i (wb_dat_i),
        .wb_sel_o (wb_sel_o),
        .wb_we_o  (wb_we_o),
        .wb_cyc_o (wb_cyc_o),
        .wb_stb_o (wb_stb_o),
        .wb_ack_i (wb_ack_i),
        .go_adr   (go_adr),
        .go_stb   (go_stb)
    );

    logic [7:0]  host_q[$];
    logic [7:0]  got_q[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc_no = 0;
    int          last_wr = -10;
    int          busy_cnt = 0;
    int          ack_b2b = 0;
    int          tx_viol = 0;
    logic        ack_prev = 1'b0;
    logic        ack_en = 1'b1;
    int          wb_txn = 0;
    logic [31:0] wb_last_adr = '0;
    logic [31:0] wb_last_dat = '0;
    logic        wb_last_we = 1'b0;
    logic [3:0]  wb_last_sel = '0;
    int          cyc_cycles = 0;
    int          go_cycles = 0;
    int          go_pulses = 0;
    logic        go_prev = 1'b0;
    logic [31:0] go_adr_seen = 32'hFFFFFFFF;

    // Host UART, transmitter busy model and Wishbone slave, all sampled 1ns after the edge.
    always @(posedge clk) begin
        #1;
        cyc_no++;
        if (rx_ack && ack_prev) ack_b2b++;
        ack_prev = rx_ack;
        if (rx_ack && host_q.size() > 0) void'(host_q.pop_front());
        rx_avail = (host_q.size() > 0);
        rx_data  = rx_avail ? host_q[0] : 8'h00;
        tx_busy = (busy_cnt > 0);
        if (busy_cnt > 0) busy_cnt--;
        if (tx_wr) begin
            if (tx_busy || (cyc_no - last_wr) < 3) tx_viol++;
            last_wr = cyc_no;
            got_q.push_back(tx_data);
            busy_cnt = 4;
        end
        if (wb_cyc_o) cyc_cycles++;
        if (wb_cyc_o && wb_stb_o && ack_en) begin
            wb_ack_i    = 1'b1;
            wb_txn++;
            wb_last_adr = wb_adr_o;
            wb_last_dat = wb_dat_o;
            wb_last_we  = wb_we_o;
            wb_last_sel = wb_sel_o;
        end else begin
            wb_ack_i = 1'b0;
        end
        if (go_stb) begin
            go_cycles++;
            go_adr_seen = go_adr;
            if (!go_prev) go_pulses++;
        end
        go_prev = go_stb;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, " rx_ack"},   {31'h0, rx_ack},   32'h0);
        check({tag, " tx_wr"},    {31'h0, tx_wr},    32'h0);
        check({tag, " tx_data"},  {24'h0, tx_data},  32'h0);
        check({tag, " cyc"},      {31'h0, wb_cyc_o}, 32'h0);
        check({tag, " stb"},      {31'h0, wb_stb_o}, 32'h0);
        check({tag, " sel"},      {28'h0, wb_sel_o}, 32'h0);
        check({tag, " we"},       {31'h0, wb_we_o},  32'h0);
        check({tag, " adr"},      wb_adr_o,          32'h0);
        check({tag, " dat_o"},    wb_dat_o,          32'h0);
        check({tag, " go_stb"},   {31'h0, go_stb},   32'h0);
        check({tag, " go_adr"},   go_adr,            32'h0);
    endtask

    task automatic send(input logic [7:0] b);
        host_q.push_back(b);
    endtask

    task automatic send_cmd(input logic [7:0] cmd, input logic [31:0] adr);
        send(cmd);
        send(adr[31:24]); send(adr[23:16]); send(adr[15:8]); send(adr[7:0]);
    endtask

    // Waits for n response bytes, then idles a while so any extra byte would show up too.
    task automatic wait_bytes(input int n, input string tag);
        int k = 0;
        while (got_q.size() < n && k < 2000) begin
            @(posedge clk);
            k++;
        end
        repeat (30) @(posedge clk);
        check({tag, " response count"}, got_q.size(), n);
    endtask

    task automatic expect_bytes(input string tag, input logic [31:0] word);
        logic [7:0] b[4];
        b[0] = word[31:24]; b[1] = word[23:16]; b[2] = word[15:8]; b[3] = word[7:0];
        for (int i = 0; i < 4; i++)
            check($sformatf("%s byte%0d", tag, i), {24'h0, (got_q.size() > i) ? got_q[i] : 8'hXX}, {24'h0, b[i]});
    endtask

    initial begin
        int k;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        // Write DEADBEEF to 0x1000
        send_cmd(8'h77, 32'h00001000);
        send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
        wait_bytes(1, "write");
        check("write txn count", wb_txn, 1);
        check("write adr", wb_last_adr, 32'h00001000);
        check("write dat", wb_last_dat, 32'hDEADBEEF);
        check("write we", {31'h0, wb_last_we}, 32'h1);
        check("write sel", {28'h0, wb_last_sel}, 32'hF);
        check("write rsp", {24'h0, got_q[0]}, 32'h4B);
        check("write cyc dropped", {31'h0, wb_cyc_o}, 32'h0);
        got_q.delete();

        // Read 0x1000 returning DEADBEEF
        wb_dat_i = 32'hDEADBEEF;
        send_cmd(8'h72, 32'h00001000);
        wait_bytes(4, "read");
        check("read txn count", wb_txn, 2);
        check("read adr", wb_last_adr, 32'h00001000);
        check("read we", {31'h0, wb_last_we}, 32'h0);
        expect_bytes("read", 32'hDEADBEEF);
        got_q.delete();

        // Go to a nonzero address, then the boot go to 0
        send_cmd(8'h67, 32'h00002000);
        wait_bytes(1, "go1");
        check("go1 pulses", go_pulses, 1);
        check("go1 width", go_cycles, 1);
        check("go1 adr", go_adr_seen, 32'h00002000);
        check("go1 rsp", {24'h0, got_q[0]}, 32'h4B);
        got_q.delete();
        go_pulses = 0; go_cycles = 0;
        send_cmd(8'h67, 32'h00000000);
        wait_bytes(1, "go0");
        check("go0 pulses", go_pulses, 1);
        check("go0 width", go_cycles, 1);
        check("go0 adr at pulse", go_adr_seen, 32'h00000000);
        check("go0 adr held", go_adr, 32'h00000000);
        check("go0 rsp", {24'h0, got_q[0]}, 32'h4B);
        check("go no bus txn", wb_txn, 2);
        got_q.delete();

        // Junk byte then read 0x44
        wb_dat_i = 32'hA1B2C3D4;
        send(8'h00);
        send_cmd(8'h72, 32'h00000044);
        wait_bytes(4, "junk read");
        check("junk read txn count", wb_txn, 3);
        check("junk read adr", wb_last_adr, 32'h00000044);
        expect_bytes("junk read", 32'hA1B2C3D4);
        got_q.delete();

`ifdef DEBUG_BRIDGE_TIMEOUT_EN
        // Slave never acks: 16 cycles of cyc, then a lone 'E'
        ack_en = 1'b0;
        cyc_cycles = 0;
        send_cmd(8'h72, 32'h00000100);
        wait_bytes(1, "timeout");
        check("timeout cyc cycles", cyc_cycles, 16);
        check("timeout rsp", {24'h0, got_q[0]}, 32'h45);
        check("timeout no ack txn", wb_txn, 3);
        ack_en = 1'b1;
        got_q.delete();
`endif

        // Reset in the middle of a bus cycle
        ack_en = 1'b0;
        send_cmd(8'h72, 32'h00000200);
        k = 0;
        while (!wb_cyc_o && k < 200) begin
            @(posedge clk);
            #2;
            k++;
        end
        check("bus reached before reset", {31'h0, wb_cyc_o}, 32'h1);
        #1;
        reset_n = 1'b0;
        #1;
        check_zero_outputs("mid-bus reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        ack_en = 1'b1;
        reset_n = 1'b1;
        got_q.delete();
        host_q.delete();
        repeat (2) @(posedge clk);
        wb_dat_i = 32'h12345678;
        send_cmd(8'h72, 32'h00000008);
        wait_bytes(4, "post-reset read");
        check("post-reset read adr", wb_last_adr, 32'h00000008);
        expect_bytes("post-reset read", 32'h12345678);

        // Handshake rules over the whole run
        check("rx_ack back-to-back", ack_b2b, 0);
        check("tx_wr pacing", tx_viol, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
